// File: rtl/pwm_pkg.sv
// Shared types and helpers for the soft-start/soft-stop PWM ramp controller.
// Holds the ramp state encoding, default geometry and the duty clamp helper.
package pwm_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } ramp_state_e;

   localparam int PERIOD_BITS_DEF = 3;
   localparam int PERIOD          = 2 ** PERIOD_BITS_DEF;

   // Requests above a full period are meaningless; they saturate to always-high.
   function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned limit);
      return (duty > limit) ? limit : duty;
   endfunction

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM counter with a registered duty compare.
// period_end marks the last count of each period so duty updates land on boundaries.
module pwm_core import pwm_pkg::*; #(
   parameter int PERIOD_BITS = PERIOD_BITS_DEF,
   parameter int DUTY_W      = $clog2(PERIOD) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [DUTY_W-1:0] cur_duty,
   output logic              pwm_out,
   output logic              period_end
);

   localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;

   logic [PERIOD_BITS-1:0] cnt;

   assign period_end = ena && (cnt == CNT_MAX);

   // Duty >= period keeps the compare true for every count, giving a solid high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         pwm_out <= 1'b0;
      end else begin
         if (ena) begin
            cnt <= cnt + PERIOD_BITS'(1);
         end
         pwm_out <= ena && (DUTY_W'(cnt) < cur_duty);
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop controller: steps the applied duty toward a host target,
// one count every ramp_div+1 PWM periods, changing duty only at period boundaries.
module pwm_ramp_ctrl import pwm_pkg::*; #(
   parameter int PERIOD_BITS = PERIOD_BITS_DEF,
   parameter int DUTY_W      = $clog2(PERIOD) + 1,
   parameter int DIV_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              load,
   input  logic [DUTY_W-1:0] target_duty,
   input  logic [DIV_W-1:0]  ramp_div,
   input  logic              bypass,
   output logic              pwm_out,
   output logic [DUTY_W-1:0] cur_duty,
   output logic              busy,
   output logic              period_tick
);

   localparam int unsigned DUTY_LIMIT = 32'(2 ** PERIOD_BITS);

   ramp_state_e       state;
   ramp_state_e       next_state;
   logic [DUTY_W-1:0] tgt;
   logic [DIV_W-1:0]  div_cnt;
   logic              period_end;

   pwm_core #(
      .PERIOD_BITS (PERIOD_BITS),
      .DUTY_W      (DUTY_W)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .cur_duty   (cur_duty),
      .pwm_out    (pwm_out),
      .period_end (period_end)
   );

   assign period_tick = period_end;

   always_comb begin
      next_state = HOLD;
      if (tgt > cur_duty) begin
         next_state = UP;
      end else if (tgt < cur_duty) begin
         next_state = DOWN;
      end
   end

   // The step only fires when the direction is stable, so a reversal never
   // moves cur_duty away from the new target, and stepping stops exactly at tgt.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tgt      <= '0;
         cur_duty <= '0;
         div_cnt  <= '0;
         state    <= HOLD;
         busy     <= 1'b0;
      end else begin
         if (load) begin
            tgt <= DUTY_W'(clamp_duty(32'(target_duty), DUTY_LIMIT));
         end
         if (ena) begin
            state <= next_state;
            busy  <= (next_state != HOLD);
            if (period_end && bypass) begin
               cur_duty <= tgt;
               div_cnt  <= '0;
            end else if ((next_state != state) || (state == HOLD)) begin
               div_cnt <= '0;
            end else if (period_end) begin
               if (div_cnt == ramp_div) begin
                  div_cnt  <= '0;
                  cur_duty <= (state == UP) ? cur_duty + DUTY_W'(1) : cur_duty - DUTY_W'(1);
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: reset, ramps, clamp, reversal, bypass, freeze, reset mid-ramp.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_ramp_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       load;
   logic [3:0] target_duty;
   logic [3:0] ramp_div;
   logic       bypass;
   logic       pwm_out;
   logic [3:0] cur_duty;
   logic       busy;
   logic       period_tick;

   int tests = 0;
   int fails = 0;

   pwm_ramp_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .load        (load),
      .target_duty (target_duty),
      .ramp_div    (ramp_div),
      .bypass      (bypass),
      .pwm_out     (pwm_out),
      .cur_duty    (cur_duty),
      .busy        (busy),
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   task automatic clk1();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the cycle after the next period_tick (counter back at 0).
   task automatic sync();
      int n;
      n = 0;
      do begin
         clk1();
         n++;
      end while ((period_tick !== 1'b1) && (n < 20));
      check("sync_tick", {7'd0, period_tick}, 8'd1);
      clk1();
   endtask

   task automatic count_high(output int hi);
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         clk1();
         if (pwm_out === 1'b1) hi++;
      end
   endtask

   task automatic do_load(input logic [3:0] t);
      load        = 1'b1;
      target_duty = t;
      clk1();
      load        = 1'b0;
   endtask

   initial begin
      int hi;
      rst_n       = 1'b0;
      ena         = 1'b1;
      load        = 1'b0;
      target_duty = 4'd0;
      ramp_div    = 4'd0;
      bypass      = 1'b0;

      // Reset held for three clocks
      for (int i = 0; i < 3; i++) begin
         clk1();
         check("rst_pwm", {7'd0, pwm_out}, 8'd0);
         check("rst_cur", {4'd0, cur_duty}, 8'd0);
         check("rst_busy", {7'd0, busy}, 8'd0);
         check("rst_tick", {7'd0, period_tick}, 8'd0);
      end

      // Ramp up to 4, one step per period
      rst_n = 1'b1;
      do_load(4'd4);
      clk1();
      check("up4_busy_start", {7'd0, busy}, 8'd1);
      for (int k = 1; k <= 4; k++) begin
         sync();
         check("up4_cur", {4'd0, cur_duty}, 8'(k));
      end
      check("up4_busy_last", {7'd0, busy}, 8'd1);
      clk1();
      check("up4_busy_drop", {7'd0, busy}, 8'd0);
      count_high(hi);
      check("duty4_high", 8'(hi), 8'd4);

      // Clamp: 15 saturates to 8, then ramp down to 0
      sync();
      do_load(4'd15);
      for (int k = 5; k <= 8; k++) begin
         sync();
         check("clamp_cur", {4'd0, cur_duty}, 8'(k));
      end
      sync();
      check("clamp_hold8", {4'd0, cur_duty}, 8'd8);
      check("clamp_busy", {7'd0, busy}, 8'd0);
      count_high(hi);
      check("duty8_high", 8'(hi), 8'd8);
      do_load(4'd0);
      for (int k = 7; k >= 0; k--) begin
         sync();
         check("down_cur", {4'd0, cur_duty}, 8'(k));
      end
      sync();
      check("down_hold0", {4'd0, cur_duty}, 8'd0);
      check("down_busy", {7'd0, busy}, 8'd0);
      count_high(hi);
      check("duty0_high", 8'(hi), 8'd0);

      // Divided ramp with a mid-ramp reversal
      ramp_div = 4'd2;
      do_load(4'd6);
      for (int k = 1; k <= 3; k++) begin
         sync();
         sync();
         check("div_wait", {4'd0, cur_duty}, 8'(k - 1));
         sync();
         check("div_step", {4'd0, cur_duty}, 8'(k));
      end
      do_load(4'd1);
      clk1();
      check("rev_busy", {7'd0, busy}, 8'd1);
      sync();
      check("rev_p1", {4'd0, cur_duty}, 8'd3);
      sync();
      check("rev_p2", {4'd0, cur_duty}, 8'd3);
      sync();
      check("rev_step2", {4'd0, cur_duty}, 8'd2);
      sync();
      sync();
      sync();
      check("rev_step1", {4'd0, cur_duty}, 8'd1);
      sync();
      check("rev_hold1", {4'd0, cur_duty}, 8'd1);
      check("rev_busy_end", {7'd0, busy}, 8'd0);

      // Bypass: jump to target at the end of the current period
      ramp_div = 4'd0;
      do_load(4'd0);
      sync();
      check("byp_pre0", {4'd0, cur_duty}, 8'd0);
      bypass = 1'b1;
      for (int i = 0; i < 6; i++) clk1();
      do_load(4'd6);
      check("byp_tick", {7'd0, period_tick}, 8'd1);
      check("byp_cur_before", {4'd0, cur_duty}, 8'd0);
      check("byp_busy_before", {7'd0, busy}, 8'd0);
      clk1();
      check("byp_cur_jump", {4'd0, cur_duty}, 8'd6);
      check("byp_busy_pulse", {7'd0, busy}, 8'd1);
      clk1();
      check("byp_busy_drop", {7'd0, busy}, 8'd0);
      check("byp_cur_hold", {4'd0, cur_duty}, 8'd6);
      bypass = 1'b0;

      // Freeze with ena low mid-ramp, then resume
      sync();
      do_load(4'd0);
      sync();
      check("frz_pre", {4'd0, cur_duty}, 8'd5);
      for (int i = 0; i < 3; i++) clk1();
      ena = 1'b0;
      for (int i = 0; i < 20; i++) begin
         clk1();
         check("frz_pwm", {7'd0, pwm_out}, 8'd0);
         check("frz_tick", {7'd0, period_tick}, 8'd0);
         check("frz_cur", {4'd0, cur_duty}, 8'd5);
      end
      check("frz_busy", {7'd0, busy}, 8'd1);
      ena = 1'b1;
      clk1();
      check("res_pwm", {7'd0, pwm_out}, 8'd1);
      check("res_tick0", {7'd0, period_tick}, 8'd0);
      clk1();
      clk1();
      check("res_tick_early", {7'd0, period_tick}, 8'd0);
      clk1();
      check("res_tick", {7'd0, period_tick}, 8'd1);
      check("res_cur_before", {4'd0, cur_duty}, 8'd5);
      clk1();
      check("res_step", {4'd0, cur_duty}, 8'd4);

      // Reset mid-ramp
      clk1();
      clk1();
      rst_n = 1'b0;
      clk1();
      check("mid_rst_cur", {4'd0, cur_duty}, 8'd0);
      check("mid_rst_busy", {7'd0, busy}, 8'd0);
      check("mid_rst_pwm", {7'd0, pwm_out}, 8'd0);
      check("mid_rst_tick", {7'd0, period_tick}, 8'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) clk1();
      check("post_rst_cur", {4'd0, cur_duty}, 8'd0);
      check("post_rst_busy", {7'd0, busy}, 8'd0);
      check("post_rst_pwm", {7'd0, pwm_out}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
